// File: rtl/stream_sink_fifo.sv
// Stream sink: FWFT buffer with registered early backpressure, a valid/ready
// output handshake and a stride checker on dequeued values.
module stream_sink_fifo #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int STRIDE     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  input  logic                          in_flush,
  output logic                          out_stall,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [15:0]                   seq_err_cnt,
  output logic                          overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [WIDTH-1:0] STRIDE_C = WIDTH'(STRIDE);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, wr_addr;
  logic [CNT_W-1:0] count_nxt;
  logic             full, pop, wr_en, drop, chk_err;
  logic             expect_valid;
  logic [WIDTH-1:0] expected;

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign full      = (count == DEPTH_C);
  // A flush swallows any pop in the same cycle.
  assign pop       = out_valid & out_ready & ~in_flush;
  assign chk_err   = pop & expect_valid & (out_data != expected);

  always_comb begin
    wr_en      = 1'b0;
    drop       = 1'b0;
    wr_addr    = wr_ptr;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (in_flush) begin
      // Concurrent beat becomes the sole entry at slot 0.
      rd_ptr_nxt = '0;
      wr_addr    = '0;
      wr_en      = in_valid;
      wr_ptr_nxt = in_valid ? PTR_W'(1) : '0;
      count_nxt  = in_valid ? CNT_W'(1) : '0;
    end else begin
      if (pop) rd_ptr_nxt = rd_ptr + PTR_W'(1);
      if (in_valid) begin
        if (!full || pop) begin
          wr_en      = 1'b1;
          wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end else begin
          drop = 1'b1;
        end
      end
      count_nxt = count + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_stall    <= 1'b0;
      overflow     <= 1'b0;
      seq_err_cnt  <= '0;
      expect_valid <= 1'b0;
      expected     <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      // Two spare slots cover the producer's one-cycle reaction plus one beat in flight.
      out_stall <= (count_nxt >= STALL_TH);
      if (drop) overflow <= 1'b1;
      if (chk_err && seq_err_cnt != 16'hFFFF) seq_err_cnt <= seq_err_cnt + 16'd1;
      if (in_flush) begin
        expect_valid <= 1'b0;
      end else if (pop) begin
        expect_valid <= 1'b1;
        expected     <= out_data + STRIDE_C;
      end
    end
  end
endmodule
